operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DW, 32, datapath width.
REQ-002 SHALL have parameter NREG, 8, number of architectural registers (address width 3).
REQ-003 SHALL have a single clock; reset is synchronous and active-low.
REQ-004 SHALL have port CLK  in  1  rising-edge clock.
REQ-005 SHALL have port RESET  in  1  active-low reset, sampled only on the CLK rising edge.
REQ-006 SHALL have port INSTR  in  32  instruction: OPCODE[31:24], RD[18:16], RT[10:8], RS[2:0], IMM[7:0].
REQ-007 SHALL have ports INSTR_VALID  in  1, and INSTR_READY  out  1: the instruction handshake.
REQ-008 SHALL have ports OUT_VALID  out  1, and OUT_READY  in  1: the execute-stage handshake.
REQ-009 SHALL have ports DATA1  out  DW, DATA2  out  DW, SELECT  out  3, and DEST  out  3: the ALU operands, ALU op code and destination register.
REQ-010 SHALL have ports WB_EN  in  1, WB_ADDR  in  3, and WB_DATA  in  DW: the register writeback port.
REQ-011 SHALL have port ILLEGAL  out  1: a one-cycle pulse marking an illegal opcode.

Function
REQ-012 SHALL decode the opcodes as follows: LOADI 0x00 -> SELECT 100, DATA2=sign-extended IMM, DATA1=0.
- MOV 0x01 -> SELECT 100, DATA2=R[RS], DATA1=0.
- ADD 0x02 -> 000, SUB 0x03 -> 001, AND 0x04 -> 010, OR 0x05 -> 011.
- For the ALU ops: DATA1=R[RT], DATA2=R[RS].
REQ-013 SHALL treat any other opcode as illegal.
REQ-014 SHALL accept an instruction on a cycle where INSTR_VALID=1 and INSTR_READY=1.
REQ-015 SHALL drive INSTR_READY = RESET & (!OUT_VALID | OUT_READY) & !hazard.
REQ-016 SHALL define hazard as: any source register the opcode uses is busy and is not being written back this cycle (WB_EN=1 and WB_ADDR equal to that source).
REQ-017 SHALL raise OUT_VALID, with registered DATA1/DATA2/SELECT/DEST, one cycle after a legal accept (latency 1).
REQ-018 SHALL hold all outputs stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 SHALL clear OUT_VALID after a cycle with OUT_READY=1 that has no new accept; back-to-back accepts SHALL sustain one instruction per cycle.
REQ-020 SHALL keep a busy bit per register: set busy[RD] on a legal accept, and clear busy[WB_ADDR] on WB_EN.
- If the set and the clear hit the same register in the same cycle, the set wins.
REQ-021 SHALL write R[WB_ADDR]=WB_DATA on every WB_EN, regardless of busy state.
REQ-022 SHALL return WB_DATA for a read of a register being written back in the same cycle (write-through bypass).
REQ-023 SHALL consume an illegal instruction with no OUT_VALID and no busy update, and pulse ILLEGAL=1 for exactly the next cycle.
REQ-024 SHALL sign-extend IMM from 8 to DW bits; all other arithmetic is the ALU's.

Reset
REQ-025 SHALL, on a rising edge with RESET=0, set every register to 0, clear all busy bits, and set OUT_VALID=0, ILLEGAL=0, DATA1=DATA2=0, SELECT=000 and DEST=000.
REQ-026 SHALL hold INSTR_READY=0 while RESET=0.
REQ-027 SHALL ignore WB_EN on a reset cycle.
REQ-028 SHALL discard any held output on reset (reset mid-operation); no output SHALL appear afterwards for that instruction.

Structure
REQ-029 SHALL take its opcode constants, SELECT codes, INSTR field positions, DW and NREG from a shared package, cpu_pkg, also used by the ALU.
REQ-030 SHALL instantiate one sub-module, reg_file: NREG x DW, two combinational read ports, one synchronous write port, with the bypass of REQ-022.
REQ-031 SHALL contain the decoder, scoreboard and output register in operand_fetch itself.

Verification
REQ-032 After reset, LOADI R1,0xFE -> next cycle OUT_VALID=1, SELECT=100, DATA2=0xFFFFFFFE, DEST=1.
REQ-033 WB R2=5, R3=3, then SUB R4,R2,R3 -> DATA1=5, DATA2=3, SELECT=001, DEST=4.
REQ-034 ADD R5,R1,R1 issued while R1 is busy -> INSTR_READY=0 until a cycle with WB_EN=1, WB_ADDR=1, WB_DATA=7; in that cycle it is accepted, with DATA1=DATA2=7.
REQ-035 OUT_READY=0 for 3 cycles with a valid output -> outputs unchanged and INSTR_READY=0; on OUT_READY=1 the next instruction is accepted the same cycle.
REQ-036 Opcode 0x1F -> ILLEGAL=1 for one cycle, OUT_VALID stays 0, busy bits unchanged.
REQ-037 RESET=0 while OUT_VALID=1 with R6 busy -> next cycle OUT_VALID=0, busy[6]=0, and R6 reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath sizing, instruction field positions,
// opcode encodings and ALU select codes. Used by operand_fetch and the ALU.
// No ports.
package cpu_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;

    // Instruction field LSB positions within INSTR[31:0]
    localparam int unsigned OPC_LSB = 24;
    localparam int unsigned OPC_W   = 8;
    localparam int unsigned RD_LSB  = 16;
    localparam int unsigned RT_LSB  = 8;
    localparam int unsigned RS_LSB  = 0;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = 8;

    typedef enum logic [7:0] {
        OP_LOADI = 8'h00,
        OP_MOV   = 8'h01,
        OP_ADD   = 8'h02,
        OP_SUB   = 8'h03,
        OP_AND   = 8'h04,
        OP_OR    = 8'h05
    } opcode_e;

    typedef enum logic [2:0] {
        SEL_ADD  = 3'b000,
        SEL_SUB  = 3'b001,
        SEL_AND  = 3'b010,
        SEL_OR   = 3'b011,
        SEL_PASS = 3'b100
    } alu_sel_e;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: NREG x DW, two combinational read ports,
// one synchronous write port with write-through bypass onto both reads.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset (clears all)
//   i_we/i_waddr/i_wdata  write port (ignored during reset)
//   i_raddr_a/o_rdata_a   read port A
//   i_raddr_b/o_rdata_b   read port B
module reg_file #(
    parameter int unsigned DW   = cpu_pkg::DW,
    parameter int unsigned NREG = cpu_pkg::NREG,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [NREG];
    logic          w_hit_a;
    logic          w_hit_b;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A read of the register being written this cycle sees the new value
    assign w_hit_a   = i_rst_n && i_we && (i_waddr == i_raddr_a);
    assign w_hit_b   = i_rst_n && i_we && (i_waddr == i_raddr_b);
    assign o_rdata_a = w_hit_a ? i_wdata : r_mem[i_raddr_a];
    assign o_rdata_b = w_hit_b ? i_wdata : r_mem[i_raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes INSTR, reads operands from reg_file, tracks
// per-register busy bits (scoreboard) to stall on pending results, and
// presents registered operands to the execute stage.
// Ports:
//   CLK, RESET                 clock, synchronous active-low reset
//   INSTR/INSTR_VALID/READY    instruction handshake
//   OUT_VALID/OUT_READY        execute-stage handshake
//   DATA1, DATA2, SELECT, DEST ALU operands, ALU op, destination register
//   WB_EN/WB_ADDR/WB_DATA      register writeback
//   ILLEGAL                    one-cycle pulse after an illegal opcode
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned DW   = cpu_pkg::DW,
    parameter int unsigned NREG = cpu_pkg::NREG
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           INSTR,
    input  logic                  INSTR_VALID,
    output logic                  INSTR_READY,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DW-1:0]         DATA1,
    output logic [DW-1:0]         DATA2,
    output logic [2:0]            SELECT,
    output logic [cpu_pkg::AW-1:0] DEST,
    input  logic                  WB_EN,
    input  logic [cpu_pkg::AW-1:0] WB_ADDR,
    input  logic [DW-1:0]         WB_DATA,
    output logic                  ILLEGAL
);

    localparam int unsigned LAW = cpu_pkg::AW;

    logic [OPC_W-1:0] w_opc;
    logic [IMM_W-1:0] w_imm;
    logic [LAW-1:0]   w_rd, w_rt, w_rs;
    logic [DW-1:0]    w_rt_data, w_rs_data;
    logic             w_legal, w_use_rt, w_use_rs;
    logic [2:0]       w_sel;
    logic [DW-1:0]    w_d1, w_d2;
    logic             w_hazard, w_accept;
    logic             w_unused_fields;

    logic [NREG-1:0]  r_busy;
    logic             r_out_valid;
    logic [DW-1:0]    r_data1, r_data2;
    logic [2:0]       r_select;
    logic [LAW-1:0]   r_dest;
    logic             r_illegal;

    assign w_opc = INSTR[OPC_LSB +: OPC_W];
    assign w_imm = INSTR[IMM_LSB +: IMM_W];
    assign w_rd  = INSTR[RD_LSB +: LAW];
    assign w_rt  = INSTR[RT_LSB +: LAW];
    assign w_rs  = INSTR[RS_LSB +: LAW];
    assign w_unused_fields = ^{INSTR[23:19], INSTR[15:11]};

    reg_file #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (LAW)
    ) u_reg_file (
        .i_clk     (CLK),
        .i_rst_n   (RESET),
        .i_we      (WB_EN),
        .i_waddr   (WB_ADDR),
        .i_wdata   (WB_DATA),
        .i_raddr_a (w_rt),
        .o_rdata_a (w_rt_data),
        .i_raddr_b (w_rs),
        .o_rdata_b (w_rs_data)
    );

    // Decoder
    always_comb begin
        w_legal  = 1'b0;
        w_use_rt = 1'b0;
        w_use_rs = 1'b0;
        w_sel    = SEL_ADD;
        w_d1     = '0;
        w_d2     = '0;
        case (w_opc)
            OP_LOADI: begin
                w_legal = 1'b1;
                w_sel   = SEL_PASS;
                w_d2    = {{(DW-IMM_W){w_imm[IMM_W-1]}}, w_imm};
            end
            OP_MOV: begin
                w_legal  = 1'b1;
                w_use_rs = 1'b1;
                w_sel    = SEL_PASS;
                w_d2     = w_rs_data;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                w_legal  = 1'b1;
                w_use_rt = 1'b1;
                w_use_rs = 1'b1;
                w_d1     = w_rt_data;
                w_d2     = w_rs_data;
                case (w_opc)
                    OP_ADD:  w_sel = SEL_ADD;
                    OP_SUB:  w_sel = SEL_SUB;
                    OP_AND:  w_sel = SEL_AND;
                    default: w_sel = SEL_OR;
                endcase
            end
            default: ;
        endcase
    end

    // A busy source is usable if its pending result is being written back now
    assign w_hazard = (w_use_rt && r_busy[w_rt] && !(WB_EN && (WB_ADDR == w_rt))) ||
                      (w_use_rs && r_busy[w_rs] && !(WB_EN && (WB_ADDR == w_rs)));

    assign INSTR_READY = RESET & (~r_out_valid | OUT_READY) & ~w_hazard;
    assign w_accept    = INSTR_VALID & INSTR_READY;

    // Scoreboard: a new destination claim overrides a same-cycle release
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_accept && w_legal && (w_rd == LAW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (WB_EN && (WB_ADDR == LAW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Output register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_out_valid <= 1'b0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_select    <= '0;
            r_dest      <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= w_accept & ~w_legal;
            if (w_accept) begin
                r_out_valid <= w_legal;
                if (w_legal) begin
                    r_data1  <= w_d1;
                    r_data2  <= w_d2;
                    r_select <= w_sel;
                    r_dest   <= w_rd;
                end
            end else if (OUT_READY) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign DATA1     = r_data1;
    assign DATA2     = r_data2;
    assign SELECT    = r_select;
    assign DEST      = r_dest;
    assign ILLEGAL   = r_illegal;

endmodule
